// File: rtl/rob_seq_ctrl_pkg.sv
// rob_seq_ctrl_pkg: shared ROB sizing, tag type and per-entry status row.
package rob_seq_ctrl_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef struct packed {
    logic valid;
    logic comp;
  } rob_row;
endpackage

// File: rtl/rob_comp_tracker.sv
// rob_comp_tracker: per-entry valid/complete bitmaps with allocate, complete and retire ports.
module rob_comp_tracker
  import rob_seq_ctrl_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  set_en_1,
  input  logic                  set_en_2,
  input  logic [TAG_W-1:0]      set_tag_1,
  input  logic [TAG_W-1:0]      set_tag_2,
  input  logic [2:0]            cmp_en,
  input  logic [2:0][TAG_W-1:0] cmp_tag,
  input  logic                  clr_en_1,
  input  logic                  clr_en_2,
  input  logic [TAG_W-1:0]      clr_tag_1,
  input  logic [TAG_W-1:0]      clr_tag_2,
  output logic [DEPTH-1:0]      valid,
  output logic [DEPTH-1:0]      comp
);
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    rob_row row;
    logic alloc_hit, ret_hit, cmp_hit;
    assign alloc_hit = (set_en_1 && set_tag_1 == TAG_W'(i)) || (set_en_2 && set_tag_2 == TAG_W'(i));
    assign ret_hit   = (clr_en_1 && clr_tag_1 == TAG_W'(i)) || (clr_en_2 && clr_tag_2 == TAG_W'(i));
    assign cmp_hit   = (cmp_en[0] && cmp_tag[0] == TAG_W'(i)) || (cmp_en[1] && cmp_tag[1] == TAG_W'(i)) ||
                       (cmp_en[2] && cmp_tag[2] == TAG_W'(i));
    // retiring wins over a late completion; completions only land on live entries
    always_ff @(posedge clk) begin
      if (rst || clr) row <= '0;
      else if (alloc_hit) row <= '{valid: 1'b1, comp: 1'b0};
      else if (ret_hit) row <= '0;
      else if (cmp_hit && row.valid) row.comp <= 1'b1;
    end
    assign valid[i] = row.valid;
    assign comp[i]  = row.comp;
  end
endmodule

// File: rtl/rob_seq_ctrl.sv
// rob_seq_ctrl: ROB head/tail/occupancy sequencing, 2-wide alloc and retire; ROB_FLUSH_EN adds a flush input.
module rob_seq_ctrl
  import rob_seq_ctrl_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ROB_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             alloc_valid_1,
  input  logic             alloc_valid_2,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag_1,
  output logic [TAG_W-1:0] alloc_tag_2,
  input  logic             result_valid_1,
  input  logic             result_valid_2,
  input  logic             result_valid_3,
  input  logic [TAG_W-1:0] result_ROB_1,
  input  logic [TAG_W-1:0] result_ROB_2,
  input  logic [TAG_W-1:0] result_ROB_3,
  input  logic             retire_en,
  output logic             rt_flag_1,
  output logic [TAG_W-1:0] rt_index_1,
  output logic             rt_flag_2,
  output logic [TAG_W-1:0] rt_index_2,
  input  logic [31:0]      tot_instr_count,
  output logic [31:0]      instr_retired,
  output logic             done,
  output logic [TAG_W:0]   rob_count,
  output logic             rob_full,
  output logic             rob_empty
);
  logic [TAG_W-1:0] head, tail;
  logic [DEPTH-1:0] valid, comp;
  logic             clr, acc_1, acc_2;
  logic [1:0]       n_acc, n_ret;
`ifdef ROB_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif
  assign alloc_ready = rob_count <= (TAG_W+1)'(DEPTH - 2);
  assign alloc_tag_1 = tail;
  assign alloc_tag_2 = tail + 1'b1;
  assign acc_1       = alloc_valid_1 & alloc_ready & ~clr;
  assign acc_2       = acc_1 & alloc_valid_2;
  assign rt_index_1  = head;
  assign rt_index_2  = head + 1'b1;
  assign rt_flag_1   = retire_en & ~done & ~clr & valid[rt_index_1] & comp[rt_index_1];
  // the second slot stops short so the final instruction retires alone
  assign rt_flag_2   = rt_flag_1 & valid[rt_index_2] & comp[rt_index_2] & (instr_retired + 32'd1 != tot_instr_count);
  assign n_acc       = {1'b0, acc_1} + {1'b0, acc_2};
  assign n_ret       = {1'b0, rt_flag_1} + {1'b0, rt_flag_2};
  assign rob_full    = rob_count == (TAG_W+1)'(DEPTH);
  assign rob_empty   = rob_count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      rob_count     <= '0;
      instr_retired <= '0;
      done          <= 1'b0;
    end else if (clr) begin
      head      <= '0;
      tail      <= '0;
      rob_count <= '0;
    end else begin
      head          <= head + TAG_W'(n_ret);
      tail          <= tail + TAG_W'(n_acc);
      rob_count     <= rob_count + (TAG_W+1)'(n_acc) - (TAG_W+1)'(n_ret);
      instr_retired <= instr_retired + 32'(n_ret);
      if (n_ret != 2'd0 && tot_instr_count != 32'd0 && instr_retired + 32'(n_ret) == tot_instr_count) done <= 1'b1;
    end
  end
  rob_comp_tracker #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_trk (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .set_en_1 (acc_1),
    .set_en_2 (acc_2),
    .set_tag_1(alloc_tag_1),
    .set_tag_2(alloc_tag_2),
    .cmp_en   ({result_valid_3, result_valid_2, result_valid_1}),
    .cmp_tag  ({result_ROB_3, result_ROB_2, result_ROB_1}),
    .clr_en_1 (rt_flag_1),
    .clr_en_2 (rt_flag_2),
    .clr_tag_1(rt_index_1),
    .clr_tag_2(rt_index_2),
    .valid    (valid),
    .comp     (comp)
  );
endmodule

// File: tb/tb_rob_seq_ctrl.sv
// tb_rob_seq_ctrl: directed plus randomized checking of rob_seq_ctrl against a queue-based ROB model.
module tb_rob_seq_ctrl;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        av1, av2, retire_en, alloc_ready, rt_flag_1, rt_flag_2, done, rob_full, rob_empty;
  logic        rv[3];
  logic [3:0]  rr[3];
  logic [3:0]  alloc_tag_1, alloc_tag_2, rt_index_1, rt_index_2;
  logic [31:0] tot, instr_retired;
  logic [4:0]  rob_count;
  int          n_chk = 0, n_fail = 0;

  rob_seq_ctrl dut (
    .clk(clk), .rst(rst),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .alloc_valid_1(av1), .alloc_valid_2(av2), .alloc_ready(alloc_ready),
    .alloc_tag_1(alloc_tag_1), .alloc_tag_2(alloc_tag_2),
    .result_valid_1(rv[0]), .result_valid_2(rv[1]), .result_valid_3(rv[2]),
    .result_ROB_1(rr[0]), .result_ROB_2(rr[1]), .result_ROB_3(rr[2]),
    .retire_en(retire_en), .rt_flag_1(rt_flag_1), .rt_index_1(rt_index_1),
    .rt_flag_2(rt_flag_2), .rt_index_2(rt_index_2), .tot_instr_count(tot),
    .instr_retired(instr_retired), .done(done), .rob_count(rob_count),
    .rob_full(rob_full), .rob_empty(rob_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, g, e);
    end
  endtask

  // model: in-flight tags in program order, per-tag completion flag
  int          q[$];
  bit          mc[16];
  int          mtail;
  logic [31:0] mret;
  bit          mdone, mlive = 0;

  always @(negedge clk) begin
    int sz, hd, nr, na;
    bit rdy, r1, r2, fl, hit;
    sz  = q.size();
    hd  = (mtail - sz + 16) % 16;
    rdy = (16 - sz) >= 2;
`ifdef ROB_FLUSH_EN
    fl = flush;
`else
    fl = 0;
`endif
    r1 = retire_en && !mdone && !fl && sz >= 1 && mc[q[0]];
    r2 = r1 && sz >= 2 && mc[q[1]] && (mret + 32'd1 != tot);
    if (mlive) begin
      chk("alloc_ready", alloc_ready, rdy);
      chk("alloc_tag_1", alloc_tag_1, mtail);
      chk("alloc_tag_2", alloc_tag_2, (mtail + 1) % 16);
      chk("rt_flag_1", rt_flag_1, r1);
      chk("rt_flag_2", rt_flag_2, r2);
      chk("rt_index_1", rt_index_1, hd);
      chk("rt_index_2", rt_index_2, (hd + 1) % 16);
      chk("instr_retired", instr_retired, mret);
      chk("done", done, mdone);
      chk("rob_count", rob_count, sz);
      chk("rob_full", rob_full, sz == 16);
      chk("rob_empty", rob_empty, sz == 0);
    end
    if (rst) begin
      q.delete();
      foreach (mc[i]) mc[i] = 0;
      mtail = 0; mret = 0; mdone = 0; mlive = 1;
    end else if (fl) begin
      q.delete();
      foreach (mc[i]) mc[i] = 0;
      mtail = 0;
    end else begin
      nr = int'(r1) + int'(r2);
      for (int k = 0; k < 3; k++) begin
        hit = 0;
        for (int j = nr; j < sz; j++) if (q[j] == int'(rr[k])) hit = 1;
        if (rv[k] && hit) mc[rr[k]] = 1;
      end
      for (int j = 0; j < nr; j++) mc[q.pop_front()] = 0;
      na = (av1 && rdy) ? (av2 ? 2 : 1) : 0;
      for (int j = 0; j < na; j++) begin
        mc[mtail] = 0;
        q.push_back(mtail);
        mtail = (mtail + 1) % 16;
      end
      mret = mret + 32'(nr);
      if (nr > 0 && tot != 0 && mret == tot) mdone = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_results();
    for (int k = 0; k < 3; k++) begin
      rv[k] = 1'b0;
      rr[k] = 4'd0;
    end
  endtask

  initial begin
    av1 = 0; av2 = 0; retire_en = 0; tot = 0;
    idle_results();
    step(); step();
    rst = 0;
    step();
    chk("reset rob_count", rob_count, 0);
    chk("reset alloc_ready", alloc_ready, 1);
    chk("reset rob_empty", rob_empty, 1);
    chk("reset instr_retired", instr_retired, 0);
    // fill all 16 entries, then one extra request that must be dropped
    av1 = 1; av2 = 1;
    repeat (9) step();
    chk("fill rob_count", rob_count, 16);
    chk("fill rob_full", rob_full, 1);
    chk("fill alloc_ready", alloc_ready, 0);
    chk("fill alloc_tag_1", alloc_tag_1, 0);
    av1 = 0; av2 = 0; retire_en = 1;
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < 3; k++) begin
        rv[k] = (3 * c + k) < 16;
        rr[k] = 4'(3 * c + k);
      end
      step();
    end
    idle_results();
    repeat (8) step();
    chk("drain rob_count", rob_count, 0);
    chk("drain instr_retired", instr_retired, 16);
    chk("drain rob_empty", rob_empty, 1);
    // program ends after 19 instructions: 2 then 1 retire
    retire_en = 0; tot = 19; av1 = 1; av2 = 1;
    repeat (3) step();
    av1 = 0; av2 = 0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) begin
        rv[k] = 1;
        rr[k] = 4'(3 * c + k);
      end
      step();
    end
    idle_results();
    step();
    chk("hold rob_count", rob_count, 6);
    step();
    chk("hold rob_count again", rob_count, 6);
    chk("hold rt_flag_1", rt_flag_1, 0);
    retire_en = 1;
    #1;
    chk("end rt_flag_1 first", rt_flag_1, 1);
    chk("end rt_flag_2 first", rt_flag_2, 1);
    step();
    chk("end instr_retired 18", instr_retired, 18);
    chk("end rt_flag_1 last", rt_flag_1, 1);
    chk("end rt_flag_2 last", rt_flag_2, 0);
    step();
    chk("end instr_retired 19", instr_retired, 19);
    chk("end done", done, 1);
    chk("end rob_count", rob_count, 3);
    chk("end rt_flag_1 after done", rt_flag_1, 0);
    rst = 1; tot = 300;
    step();
    rst = 0;
    repeat (3000) begin
      rst = $urandom_range(0, 299) == 0;
      if (rst) tot = $urandom_range(0, 300);
      av1 = $urandom_range(0, 9) < 7;
      av2 = $urandom_range(0, 9) < 6;
      retire_en = $urandom_range(0, 9) < 8;
      for (int k = 0; k < 3; k++) begin
        rv[k] = $urandom_range(0, 1);
        rr[k] = 4'($urandom_range(0, 15));
      end
`ifdef ROB_FLUSH_EN
      flush = $urandom_range(0, 49) == 0;
`endif
      step();
    end
    rst = 0; flush = 0; av1 = 0; av2 = 0; retire_en = 0;
    idle_results();
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
